bc_result_deser: RTL and testbench

BC_RESULT_DESER -- requirements
Module: bc_result_deser

---
 rtl/bc_mac_pkg.sv | 11 +
 rtl/bc_fifo2.sv | 46 ++++
 rtl/bc_result_deser.sv | 123 ++++++++++++
 tb/tb_bc_result_deser.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bc_mac_pkg.sv
// Shared types and constants for the bitblock result deserialiser.
package bc_mac_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_COLLECT
  } bc_st_e;

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/bc_fifo2.sv
// Two-entry output FIFO; a push is taken when full if a pop frees a slot on the same edge.
module bc_fifo2
  import bc_mac_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic             wp_q;
  logic             rp_q;
  logic [1:0]       cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt_q == 2'd0);
  assign full    = (cnt_q == 2'd2);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rp_q];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wp_q] <= din;
        wp_q        <= ~wp_q;
      end
      if (do_pop) rp_q <= ~rp_q;
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/bc_result_deser.sv
// Serial LSB-first result word assembler with 2-entry output FIFO.
// Define BC_DESER_DROPCNT_EN to add the saturating drop_cnt output.
module bc_result_deser
  import bc_mac_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             bit_in,
  input  logic             bit_vld,
  input  logic             sof,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf,
  output logic             frame_err
`ifdef BC_DESER_DROPCNT_EN
  ,
  output logic [7:0]       drop_cnt
`endif
);

  bc_st_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             ovf_q, ovf_d;
  logic             ferr_q, ferr_d;
  logic             push;
  logic             full;
  logic             empty;
  logic             drop;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    ferr_d  = ferr_q;
    push    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bit_vld && sof) begin
          shift_d    = '0;
          shift_d[0] = bit_in;
          cnt_d      = CW'(1);
          state_d    = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (bit_vld && sof) begin
          // Mid-word sof: abandon partial word, restart at bit 0
          ferr_d     = 1'b1;
          shift_d    = '0;
          shift_d[0] = bit_in;
          cnt_d      = CW'(1);
        end else if (bit_vld) begin
          shift_d[cnt_q] = bit_in;
          if (cnt_q == CW'(WIDTH - 1)) begin
            push    = 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A full FIFO only drops when the consumer is not also popping
  assign drop  = push & full & ~out_ready;
  assign ovf_d = ovf_q | drop;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
    end
  end

  bc_fifo2 #(
    .WIDTH(WIDTH)
  ) u_fifo (
    .clk  (clk),
    .rstn (rstn),
    .push (push),
    .din  (shift_d),
    .pop  (out_ready),
    .dout (out_data),
    .full (full),
    .empty(empty)
  );

  assign out_valid = ~empty;
  assign ovf       = ovf_q;
  assign frame_err = ferr_q;

`ifdef BC_DESER_DROPCNT_EN
  logic [7:0] drop_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      drop_q <= 8'd0;
    end else if (drop && drop_q != 8'hFF) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_bc_result_deser.sv
// Scoreboard bench for bc_result_deser against a word-level reference model.
module tb_bc_result_deser;

  localparam int W = 8;

  logic         clk       = 1'b0;
  logic         rstn      = 1'b0;
  logic         bit_in    = 1'b0;
  logic         bit_vld   = 1'b0;
  logic         sof       = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         ovf;
  logic         frame_err;
`ifdef BC_DESER_DROPCNT_EN
  logic [7:0]   drop_cnt;
`endif

  always #5 clk = ~clk;

  bc_result_deser #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .bit_in   (bit_in),
    .bit_vld  (bit_vld),
    .sof      (sof),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ovf      (ovf),
    .frame_err(frame_err)
`ifdef BC_DESER_DROPCNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  int           n_cmp = 0;
  int           n_fail = 0;
  int           n_out = 0;
  logic [W-1:0] exp_q[$];
  bit           mon_en = 1'b0;

  int           m_occ;
  bit           m_col;
  int           m_n;
  logic [W-1:0] m_word;
  bit           m_ovf;
  bit           m_ferr;
  int           m_drops;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Word-level model of one clock edge
  task automatic model_edge(input bit v, input bit s, input bit b, input bit rdy);
    bit done;
    bit pop;
    done = 1'b0;
    pop  = rdy && (m_occ > 0);
    if (v) begin
      if (s) begin
        if (m_col) m_ferr = 1'b1;
        m_col  = 1'b1;
        m_word = W'(b);
        m_n    = 1;
      end else if (m_col) begin
        m_word = m_word | (W'(b) << m_n);
        m_n++;
        if (m_n == W) begin
          done  = 1'b1;
          m_col = 1'b0;
        end
      end
    end
    if (done) begin
      if (m_occ == 2 && !pop) begin
        m_ovf = 1'b1;
        if (m_drops < 255) m_drops++;
      end else begin
        exp_q.push_back(m_word);
        m_occ++;
      end
    end
    if (pop) m_occ--;
  endtask

  task automatic step(input bit v, input bit s, input bit b);
    bit_vld = v;
    sof     = s;
    bit_in  = b;
    @(posedge clk);
    model_edge(v, s, b, out_ready);
    #1;
    bit_vld = 1'b0;
    sof     = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w, input int gap);
    for (int i = 0; i < W; i++) begin
      step(1'b1, i == 0, w[i]);
      repeat (gap) step(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rstn   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    m_occ   = 0;
    m_col   = 1'b0;
    m_n     = 0;
    m_word  = '0;
    m_ovf   = 1'b0;
    m_ferr  = 1'b0;
    m_drops = 0;
    exp_q.delete();
    rstn   = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 20 && m_occ > 0; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic chk_flags(input string nm);
    chk({nm, "_ovf"}, 32'(ovf), 32'(m_ovf));
    chk({nm, "_ferr"}, 32'(frame_err), 32'(m_ferr));
`ifdef BC_DESER_DROPCNT_EN
    chk({nm, "_dropcnt"}, 32'(drop_cnt), 32'(m_drops));
`endif
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("valid", 32'(out_valid), 32'(m_occ > 0));
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_out: got %0h expected none", out_data);
        end else begin
          chk("data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int base;
    do_reset();

    // LSB-first 1,0,1,1,0,0,1,0 -> 8'h4D one cycle after last bit
    out_ready = 1'b1;
    send_word(8'h4D, 0);
    chk("t32_valid", 32'(out_valid), 32'd1);
    chk("t32_data", 32'(out_data), 32'h4D);
    repeat (2) step(1'b0, 1'b0, 1'b0);

    send_word(8'h4D, 3);
    drain();
    chk("t33_ovf", 32'(ovf), 32'd0);
    chk("t33_ferr", 32'(frame_err), 32'd0);

    // Overflow: third word dropped, first two retained in order
    out_ready = 1'b0;
    send_word(8'h01, 0);
    send_word(8'h02, 0);
    send_word(8'h03, 0);
    chk("t34_ovf", 32'(ovf), 32'd1);
    chk("t34_head", 32'(out_data), 32'h01);
`ifdef BC_DESER_DROPCNT_EN
    chk("t34_dropcnt", 32'(drop_cnt), 32'd1);
`endif
    base = n_out;
    drain();
    chk("t34_nout", 32'(n_out - base), 32'd2);
    chk_flags("t34");

    // Mid-word sof after 5 bits
    do_reset();
    out_ready = 1'b1;
    base = n_out;
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'(i & 1));
    send_word(8'hA5, 0);
    drain();
    chk("t35_ferr", 32'(frame_err), 32'd1);
    chk("t35_nout", 32'(n_out - base), 32'd1);

    // Reset mid-word discards partial word silently
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
    do_reset();
    base = n_out;
    out_ready = 1'b1;
    send_word(8'hFF, 0);
    drain();
    chk("t36_nout", 32'(n_out - base), 32'd1);
    chk_flags("t36");
    chk("t36_ovf0", 32'(ovf), 32'd0);

    // Push and pop on the same edge while full
    out_ready = 1'b0;
    send_word(8'h11, 0);
    send_word(8'h22, 0);
    for (int i = 0; i < W - 1; i++) step(1'b1, i == 0, 1'((8'h33 >> i) & 1));
    out_ready = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    chk("t37_ovf", 32'(ovf), 32'd0);
    base = n_out;
    drain();
    chk("t37_nout", 32'(n_out - base), 32'd2);
    chk_flags("t37");

    // Randomised traffic with truncated words and backpressure
    do_reset();
    for (int k = 0; k < 150; k++) begin
      logic [W-1:0] w;
      int nb;
      w  = W'($urandom);
      nb = ($urandom % 8 == 0) ? $urandom_range(1, W - 1) : W;
      for (int i = 0; i < nb; i++) begin
        out_ready = ($urandom % 3) != 0;
        step(1'b1, i == 0, w[i]);
        repeat ($urandom % 3) step(1'b0, 1'b0, 1'b0);
      end
      if (!m_col && ($urandom % 4 == 0)) step(1'b1, 1'b0, 1'($urandom));
    end
    drain();
    chk_flags("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
